dec_fsm_3: RTL

DEC_FSM_3 -- requirements
Module: dec_fsm_3

---
 rtl/dec_fsm_3_if.sv | 62 ++++++
 rtl/dec_fsm_3.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dec_fsm_3_if.sv
// Byte-stream demux bus: input byte FIFO pop side plus the varint and raw FIFO push sides.
// Latency: none, this is wiring only.
// Backpressure: carried by the *_full and in_fifo_empty flags into the FSM.
interface dec_fsm_3_if;
   // Input byte FIFO: {last_raw, is_varint, byte}
   logic       in_fifo_empty;
   logic       in_fifo_pop;
   logic [9:0] in_fifo_q;

   // Varint output FIFO
   logic       varint_fifo_full;
   logic       varint_fifo_push;
   logic       varint_fifo_clr;
   logic [7:0] varint_fifo_d;
   logic [9:0] varint_index_d;

   // Raw output FIFO
   logic       raw_data_fifo_full;
   logic       raw_data_fifo_push;
   logic       raw_data_fifo_clr;
   logic [7:0] raw_data_fifo_d;
   logic [9:0] raw_data_index_d;

   // Sticky over-length varint error
   logic       varint_overlong;

   // The demux FSM side
   modport master (
      input  in_fifo_empty,
      input  in_fifo_q,
      input  varint_fifo_full,
      input  raw_data_fifo_full,
      output in_fifo_pop,
      output varint_fifo_push,
      output varint_fifo_clr,
      output varint_fifo_d,
      output varint_index_d,
      output raw_data_fifo_push,
      output raw_data_fifo_clr,
      output raw_data_fifo_d,
      output raw_data_index_d,
      output varint_overlong
   );

   // The FIFO / environment side
   modport slave (
      output in_fifo_empty,
      output in_fifo_q,
      output varint_fifo_full,
      output raw_data_fifo_full,
      input  in_fifo_pop,
      input  varint_fifo_push,
      input  varint_fifo_clr,
      input  varint_fifo_d,
      input  varint_index_d,
      input  raw_data_fifo_push,
      input  raw_data_fifo_clr,
      input  raw_data_fifo_d,
      input  raw_data_index_d,
      input  varint_overlong
   );
endinterface

// File: rtl/dec_fsm_3.sv
// Demultiplexes one tagged byte stream into a varint FIFO and a raw FIFO, tagging each byte with a 10-bit field index.
// Latency: 4 cycles per byte (WAIT_DATA, POP, DECODE, PUSH) when the target FIFO has room.
// Backpressure: stalls in V_FULL/R_FULL only while the FIFO selected by the current byte is full; no pop while stalled.
// Optional varint length check: define DEC_FSM_3_VARINT_LEN_CHECK_EN to build it (default build leaves it out).
module dec_fsm_3 #(
   parameter int VARINT_MAX_BYTES = 10
) (
   input  logic          clk,
   input  logic          reset,
   dec_fsm_3_if.master   bus
);

   // One-hot state encoding
   localparam logic [7:0] S_INIT      = 8'b0000_0001;
   localparam logic [7:0] S_WAIT_DATA = 8'b0000_0010;
   localparam logic [7:0] S_POP       = 8'b0000_0100;
   localparam logic [7:0] S_DECODE    = 8'b0000_1000;
   localparam logic [7:0] S_V_PUSH    = 8'b0001_0000;
   localparam logic [7:0] S_R_PUSH    = 8'b0010_0000;
   localparam logic [7:0] S_V_FULL    = 8'b0100_0000;
   localparam logic [7:0] S_R_FULL    = 8'b1000_0000;

   logic [7:0] state_q, state_d;
   logic [9:0] index_q, index_d;
   // Latched byte: {last_raw, data}. The varint/raw flag only steers the
   // DECODE branch, after which the state itself remembers it.
   logic [8:0] byte_q, byte_d;

   // Varint field terminates on this push (drives the index increment)
   logic       v_term;

`ifdef DEC_FSM_3_VARINT_LEN_CHECK_EN
   // Count value seen while pushing the VARINT_MAX_BYTES-th byte of a field
   localparam logic [3:0] VCNT_LAST = 4'(VARINT_MAX_BYTES - 1);

   logic [3:0] vcnt_q, vcnt_d;
   logic       overlong_q, overlong_d;
   logic       v_at_limit;

   assign v_at_limit = (vcnt_q == VCNT_LAST);
   // A continuation byte at the limit closes the field as if it had terminated
   assign v_term     = ~byte_q[7] | v_at_limit;

   // Varint length counter and sticky over-length flag
   always_comb begin
      vcnt_d     = vcnt_q;
      overlong_d = overlong_q;
      if (state_q == S_INIT) begin
         vcnt_d = 4'd0;
      end else if (state_q == S_V_PUSH) begin
         if (v_term) begin
            vcnt_d = 4'd0;
         end else begin
            vcnt_d = vcnt_q + 4'd1;
         end
         if (byte_q[7] && v_at_limit) begin
            overlong_d = 1'b1;
         end
      end else if ((state_q == S_R_PUSH) && byte_q[8]) begin
         // A raw field closing also starts a fresh field for the counter
         vcnt_d = 4'd0;
      end
   end

   // Length-check registers
   always_ff @(posedge clk) begin
      if (reset) begin
         vcnt_q     <= 4'd0;
         overlong_q <= 1'b0;
      end else begin
         vcnt_q     <= vcnt_d;
         overlong_q <= overlong_d;
      end
   end

   assign bus.varint_overlong = overlong_q;
`else
   // Only a clear bit 7 ends a varint field in this build
   assign v_term = ~byte_q[7];
   assign bus.varint_overlong = 1'b0;

   // VARINT_MAX_BYTES only sizes the length check, which this build leaves out
   if (VARINT_MAX_BYTES > 0) begin : g_no_len_check
   end
`endif

   // Next-state, index and byte register logic
   always_comb begin
      state_d = S_INIT;
      index_d = index_q;
      byte_d  = byte_q;
      case (state_q)
         S_INIT: begin
            index_d = 10'd0;
            byte_d  = 9'd0;
            state_d = S_WAIT_DATA;
         end
         S_WAIT_DATA: begin
            state_d = bus.in_fifo_empty ? S_WAIT_DATA : S_POP;
         end
         S_POP: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            // in_fifo_q is valid the cycle after the pop
            byte_d = {bus.in_fifo_q[9], bus.in_fifo_q[7:0]};
            if (bus.in_fifo_q[8]) begin
               state_d = bus.varint_fifo_full ? S_V_FULL : S_V_PUSH;
            end else begin
               state_d = bus.raw_data_fifo_full ? S_R_FULL : S_R_PUSH;
            end
         end
         S_V_FULL: begin
            state_d = bus.varint_fifo_full ? S_V_FULL : S_V_PUSH;
         end
         S_R_FULL: begin
            state_d = bus.raw_data_fifo_full ? S_R_FULL : S_R_PUSH;
         end
         S_V_PUSH: begin
            // Tag already went out with the pre-increment index; 10 bits wrap 1023 -> 0
            if (v_term) begin
               index_d = index_q + 10'd1;
            end
            state_d = S_WAIT_DATA;
         end
         S_R_PUSH: begin
            if (byte_q[8]) begin
               index_d = index_q + 10'd1;
            end
            state_d = S_WAIT_DATA;
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // State, index and byte registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_INIT;
         index_q <= 10'd0;
         byte_q  <= 9'd0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         byte_q  <= byte_d;
      end
   end

   // Strobes are decoded from full state equality, so an illegal code drives none of them;
   // they are held low while reset is asserted.
   assign bus.in_fifo_pop        = ~reset & (state_q == S_POP);
   assign bus.varint_fifo_push   = ~reset & (state_q == S_V_PUSH);
   assign bus.raw_data_fifo_push = ~reset & (state_q == S_R_PUSH);
   assign bus.varint_fifo_clr    = ~reset & (state_q == S_INIT);
   assign bus.raw_data_fifo_clr  = ~reset & (state_q == S_INIT);

   // Data and tag presented to both FIFOs; only the pushed one takes them
   assign bus.varint_fifo_d    = byte_q[7:0];
   assign bus.varint_index_d   = index_q;
   assign bus.raw_data_fifo_d  = byte_q[7:0];
   assign bus.raw_data_index_d = index_q;

endmodule
